// File: rtl/nibbler_sequencer.sv
// Nibbler sequencer: fetch/decode/execute control, PC, IR and C/Z flags.
// Optional NIBBLER_SINGLE_STEP_EN adds input step and a PAUSE state.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mem_*               program/data memory request/ready handshake
//   acc_q               accumulator value (store data, OUT data)
//   alu_*               ALU control word, B operand and ALU results
//   acc_load, io_out_wr one-cycle strobes for accumulator / output port
//   io_in               input port, routed to alu_b for IN
//   pc, carry_flag,
//   zero_flag, halted   architectural status
//   step                (NIBBLER_SINGLE_STEP_EN only) release from PAUSE
module nibbler_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
`ifdef NIBBLER_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  output logic [3:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  input  logic            mem_ready,
  input  logic [3:0]      acc_q,
  output logic            alu_carry_in,
  output logic            alu_mode,
  output logic [3:0]      alu_func,
  output logic [3:0]      alu_b,
  input  logic [3:0]      alu_result,
  input  logic            alu_carry,
  output logic            acc_load,
  input  logic [3:0]      io_in,
  output logic            io_out_wr,
  output logic [PC_W-1:0] pc,
  output logic            carry_flag,
  output logic            zero_flag,
  output logic            halted
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUBI = 4'h2;
  localparam logic [3:0] OP_NORI = 4'h3;
  localparam logic [3:0] OP_LIT  = 4'h4;
  localparam logic [3:0] OP_ADDM = 4'h5;
  localparam logic [3:0] OP_SUBM = 4'h6;
  localparam logic [3:0] OP_NORM = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_IN   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // {carry_in, mode, func}
  localparam logic [5:0] CW_PASSA = 6'b1_0_0000;
  localparam logic [5:0] CW_SUB   = 6'b0_0_0110;
  localparam logic [5:0] CW_PASSB = 6'b0_1_1010;
  localparam logic [5:0] CW_ADD   = 6'b1_0_1001;
  localparam logic [5:0] CW_NOR   = 6'b0_1_0001;

`ifdef NIBBLER_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_F1, S_F2, S_MRD, S_EXEC, S_MWR, S_HALT, S_PAUSE
  } state_t;
  // Instruction boundaries park in PAUSE until step.
  localparam state_t S_NEXT = S_PAUSE;
`else
  typedef enum logic [2:0] {
    S_F1, S_F2, S_MRD, S_EXEC, S_MWR, S_HALT
  } state_t;
  localparam state_t S_NEXT = S_F1;
`endif

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] addr_q;
  logic [7:0]      ir_q;
  logic [3:0]      opnd_q;
  logic            c_q;
  logic            z_q;

  logic [3:0]      op;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] byte_addr;
  logic            is_arith;
  logic            take_jump;
  logic [5:0]      ctl;

  assign op        = ir_q[7:4];
  assign pc_inc    = pc_q + PC_W'(1);
  assign byte_addr = PC_W'(mem_rdata);
  assign is_arith  = op inside {OP_ADDI, OP_SUBI, OP_NORI,
                                OP_ADDM, OP_SUBM, OP_NORM};
  assign take_jump = (op == OP_JMP)
                   | ((op == OP_JZ) & z_q)
                   | ((op == OP_JC) & c_q);

  function automatic logic needs_addr(input logic [3:0] o);
    return o inside {OP_ADDM, OP_SUBM, OP_NORM, OP_LD,
                     OP_ST, OP_JMP, OP_JZ, OP_JC};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_F1;
      pc_q    <= PC_W'(RESET_PC);
      addr_q  <= '0;
      ir_q    <= '0;
      opnd_q  <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_F1: if (mem_ready) begin
          ir_q <= mem_rdata;
          pc_q <= pc_inc;
          if (needs_addr(mem_rdata[7:4]))
            state_q <= S_F2;
          else if (mem_rdata[7:4] == OP_HALT)
            state_q <= S_HALT;
          else
            state_q <= S_EXEC;
        end
        S_F2: if (mem_ready) begin
          addr_q <= byte_addr;
          pc_q   <= pc_inc;
          if (op inside {OP_ADDM, OP_SUBM, OP_NORM, OP_LD})
            state_q <= S_MRD;
          else if (op == OP_ST)
            state_q <= S_MWR;
          else
            state_q <= S_EXEC;
        end
        S_MRD: if (mem_ready) begin
          opnd_q  <= mem_rdata[3:0];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_arith) begin
            c_q <= alu_carry;
            z_q <= (alu_result == 4'h0);
          end
          if (take_jump)
            pc_q <= addr_q;
          state_q <= S_NEXT;
        end
        S_MWR: if (mem_ready) state_q <= S_NEXT;
        S_HALT: state_q <= S_HALT;
`ifdef NIBBLER_SINGLE_STEP_EN
        S_PAUSE: if (step) state_q <= S_F1;
`endif
        default: state_q <= S_F1;
      endcase
    end
  end

  // B operand depends only on the opcode; it is don't-care outside EXEC.
  always_comb begin
    alu_b = 4'h0;
    case (op)
      OP_ADDI, OP_SUBI,
      OP_NORI, OP_LIT:  alu_b = ir_q[3:0];
      OP_ADDM, OP_SUBM,
      OP_NORM, OP_LD:   alu_b = opnd_q;
      OP_IN:            alu_b = io_in;
      default:          alu_b = 4'h0;
    endcase
  end

  // Moore decode; reset masks every strobe in the reset cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = acc_q;
    acc_load  = 1'b0;
    io_out_wr = 1'b0;
    ctl       = CW_PASSA;
    if (!reset) begin
      unique case (state_q)
        S_F1, S_F2: mem_req = 1'b1;
        S_MRD: begin
          mem_req  = 1'b1;
          mem_addr = addr_q;
        end
        S_MWR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = addr_q;
        end
        S_EXEC: begin
          case (op)
            OP_ADDI, OP_ADDM: begin
              ctl      = CW_ADD;
              acc_load = 1'b1;
            end
            OP_SUBI, OP_SUBM: begin
              ctl      = CW_SUB;
              acc_load = 1'b1;
            end
            OP_NORI, OP_NORM: begin
              ctl      = CW_NOR;
              acc_load = 1'b1;
            end
            OP_LIT, OP_LD, OP_IN: begin
              ctl      = CW_PASSB;
              acc_load = 1'b1;
            end
            OP_OUT:  io_out_wr = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign {alu_carry_in, alu_mode, alu_func} = ctl;

  assign pc         = pc_q;
  assign carry_flag = c_q;
  assign zero_flag  = z_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Bench for nibbler_sequencer: memory, ALU and accumulator models,
// with queued expectations for memory writes and output-port writes.
module tb_nibbler_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready = 1'b1;
  logic [3:0] acc = 4'h0;
  logic       alu_carry_in, alu_mode;
  logic [3:0] alu_func, alu_b;
  logic [3:0] alu_res;
  logic       alu_c;
  logic       acc_load;
  logic [3:0] io_in = 4'h9;
  logic       io_out_wr;
  logic [7:0] pc;
  logic       carry_flag, zero_flag, halted;
`ifdef NIBBLER_SINGLE_STEP_EN
  logic       step = 1'b0;
`endif

  logic [7:0] mem [256];

  typedef struct {
    logic [7:0] addr;
    logic [3:0] data;
  } wr_t;
  wr_t        wq[$];
  logic [3:0] oq[$];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  nibbler_sequencer #(.PC_W(8), .RESET_PC(0)) dut (
    .clk(clk),
    .reset(reset),
`ifdef NIBBLER_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .acc_q(acc),
    .alu_carry_in(alu_carry_in),
    .alu_mode(alu_mode),
    .alu_func(alu_func),
    .alu_b(alu_b),
    .alu_result(alu_res),
    .alu_carry(alu_c),
    .acc_load(acc_load),
    .io_in(io_in),
    .io_out_wr(io_out_wr),
    .pc(pc),
    .carry_flag(carry_flag),
    .zero_flag(zero_flag),
    .halted(halted)
  );

  assign mem_rdata = mem[mem_addr];

  // Reference ALU for the five control words the sequencer uses.
  always_comb begin
    logic [4:0] s5;
    s5      = {1'b0, acc} + {1'b0, alu_b};
    alu_res = acc;
    alu_c   = 1'b0;
    case ({alu_carry_in, alu_mode, alu_func})
      6'b101001: begin
        alu_res = s5[3:0];
        alu_c   = s5[4];
      end
      6'b000110: begin
        alu_res = acc - alu_b;
        alu_c   = (acc >= alu_b);
      end
      6'b011010: alu_res = alu_b;
      6'b010001: alu_res = ~(acc | alu_b);
      default: ;
    endcase
  end

  always @(posedge clk)
    if (acc_load) acc <= alu_res;

  // Transfers complete at the next rising edge; inputs only move at
  // falling edges, so sampling 1 unit later sees the settled request.
  always @(negedge clk) begin
    #1;
    if (!reset && mem_req && mem_we && mem_ready) begin
      total++;
      if (wq.size() == 0) begin
        $display("FAIL mem_write: unexpected write addr=%0h data=%0h",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data)
          $display("FAIL mem_write: got %0h/%0h expected %0h/%0h",
                   mem_addr, mem_wdata, e.addr, e.data);
        else passed++;
      end
    end
    if (!reset && io_out_wr) begin
      total++;
      if (oq.size() == 0) begin
        $display("FAIL io_out: unexpected write data=%0h", acc);
      end else begin
        logic [3:0] e;
        e = oq.pop_front();
        if (acc !== e)
          $display("FAIL io_out: got %0h expected %0h", acc, e);
        else passed++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_mem();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || acc_load !== 1'b0 || io_out_wr !== 1'b0)
      $display("FAIL reset_strobes: got %b%b%b expected 000",
               mem_req, acc_load, io_out_wr);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if ({pc, carry_flag, zero_flag, halted} !== 11'h000)
      $display("FAIL reset_state: got pc=%0h c=%b z=%b h=%b expected 0",
               pc, carry_flag, zero_flag, halted);
    else passed++;
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00)
      $display("FAIL reset_fetch: got req=%b we=%b addr=%0h expected 1 0 0",
               mem_req, mem_we, mem_addr);
    else passed++;
  endtask

  task automatic test_imm();
    clear_mem();
    mem[0] = 8'h45;
    mem[1] = 8'h13;
    do_reset();
    cyc(3);
    total++;
    if ({alu_carry_in, alu_mode, alu_func} !== 6'b101001 ||
        alu_b !== 4'h3 || acc_load !== 1'b1)
      $display("FAIL addi_ctl: got %b b=%0h ld=%b expected 101001 b=3 ld=1",
               {alu_carry_in, alu_mode, alu_func}, alu_b, acc_load);
    else passed++;
    cyc(1);
    total++;
    if (acc !== 4'h8 || carry_flag !== 1'b0 || zero_flag !== 1'b0 ||
        pc !== 8'h02)
      $display("FAIL addi_result: got acc=%0h c=%b z=%b pc=%0h expected 8 0 0 2",
               acc, carry_flag, zero_flag, pc);
    else passed++;
  endtask

  task automatic test_branch();
    clear_mem();
    mem[0]     = 8'h4F;
    mem[1]     = 8'h11;
    mem[2]     = 8'hE0;
    mem[3]     = 8'h10;
    mem[8'h10] = 8'h11;
    mem[8'h11] = 8'hD0;
    mem[8'h12] = 8'h40;
    do_reset();
    cyc(4);
    total++;
    if (acc !== 4'h0 || carry_flag !== 1'b1 || zero_flag !== 1'b1 ||
        pc !== 8'h02)
      $display("FAIL carry_wrap: got acc=%0h c=%b z=%b pc=%0h expected 0 1 1 2",
               acc, carry_flag, zero_flag, pc);
    else passed++;
    cyc(3);
    total++;
    if (pc !== 8'h10)
      $display("FAIL jc_taken: got pc=%0h expected 10", pc);
    else passed++;
    cyc(2);
    total++;
    if (acc !== 4'h1 || carry_flag !== 1'b0 || zero_flag !== 1'b0)
      $display("FAIL addi_clr: got acc=%0h c=%b z=%b expected 1 0 0",
               acc, carry_flag, zero_flag);
    else passed++;
    cyc(3);
    total++;
    if (pc !== 8'h13)
      $display("FAIL jz_not_taken: got pc=%0h expected 13", pc);
    else passed++;
  endtask

  task automatic test_store_stall();
    clear_mem();
    mem[0] = 8'h43;
    mem[1] = 8'h90;
    mem[2] = 8'h20;
    mem[3] = 8'hF0;
    wq.push_back('{addr: 8'h20, data: 4'h3});
    do_reset();
    cyc(4);
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      #1;
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h20 ||
          mem_wdata !== 4'h3)
        $display("FAIL st_hold%0d: got req=%b we=%b addr=%0h d=%0h expected 1 1 20 3",
                 k, mem_req, mem_we, mem_addr, mem_wdata);
      else passed++;
      @(negedge clk);
    end
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h03)
      $display("FAIL st_to_f1: got req=%b we=%b addr=%0h expected 1 0 3",
               mem_req, mem_we, mem_addr);
    else passed++;
  endtask

  task automatic test_subm_halt();
    int n;
    clear_mem();
    mem[0]     = 8'h45;
    mem[1]     = 8'h60;
    mem[2]     = 8'h30;
    mem[3]     = 8'hB0;
    mem[4]     = 8'hF0;
    mem[8'h30] = 8'h02;
    oq.push_back(4'h3);
    do_reset();
    cyc(5);
    total++;
    if ({alu_carry_in, alu_mode, alu_func} !== 6'b000110 ||
        alu_b !== 4'h2 || acc_load !== 1'b1)
      $display("FAIL subm_ctl: got %b b=%0h ld=%b expected 000110 b=2 ld=1",
               {alu_carry_in, alu_mode, alu_func}, alu_b, acc_load);
    else passed++;
    cyc(1);
    total++;
    if (acc !== 4'h3 || carry_flag !== 1'b1 || zero_flag !== 1'b0)
      $display("FAIL subm_result: got acc=%0h c=%b z=%b expected 3 1 0",
               acc, carry_flag, zero_flag);
    else passed++;
    n = 0;
    while (halted !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (halted !== 1'b1)
      $display("FAIL halt_enter: got halted=%b expected 1", halted);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (mem_req !== 1'b0 || acc_load !== 1'b0 || io_out_wr !== 1'b0 ||
          halted !== 1'b1 || pc !== 8'h05)
        $display("FAIL halt_idle%0d: got req=%b ld=%b out=%b h=%b pc=%0h expected 0 0 0 1 5",
                 k, mem_req, acc_load, io_out_wr, halted, pc);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0] = 8'hC0;
    mem[1] = 8'h55;
    do_reset();
    total++;
    if (halted !== 1'b0)
      $display("FAIL halt_exit: got halted=%b expected 0", halted);
    else passed++;
    cyc(1);
    mem_ready = 1'b0;
    cyc(2);
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h01 || pc !== 8'h01)
      $display("FAIL f2_stall: got req=%b addr=%0h pc=%0h expected 1 1 1",
               mem_req, mem_addr, pc);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0)
      $display("FAIL mid_reset_req: got %b expected 0", mem_req);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (pc !== 8'h00 || halted !== 1'b0 || mem_req !== 1'b1 ||
        mem_we !== 1'b0 || mem_addr !== 8'h00)
      $display("FAIL mid_reset_state: got pc=%0h h=%b req=%b we=%b addr=%0h expected 0 0 1 0 0",
               pc, halted, mem_req, mem_we, mem_addr);
    else passed++;
    mem_ready = 1'b1;
  endtask

`ifdef NIBBLER_SINGLE_STEP_EN
  task automatic test_single_step();
    clear_mem();
    step = 1'b0;
    do_reset();
    cyc(6);
    total++;
    if (pc !== 8'h01 || mem_req !== 1'b0)
      $display("FAIL pause_hold: got pc=%0h req=%b expected 1 0",
               pc, mem_req);
    else passed++;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    cyc(6);
    total++;
    if (pc !== 8'h02 || mem_req !== 1'b0)
      $display("FAIL single_step: got pc=%0h req=%b expected 2 0",
               pc, mem_req);
    else passed++;
  endtask
`endif

  task automatic test_drain();
    cyc(2);
    total++;
    if (wq.size() != 0 || oq.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
               wq.size(), oq.size());
    else passed++;
  endtask

  initial begin
    test_reset();
`ifdef NIBBLER_SINGLE_STEP_EN
    test_single_step();
`else
    test_imm();
    test_branch();
    test_store_stall();
    test_subm_halt();
    test_reset_mid();
`endif
    test_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
